// File: rtl/rf_iw_pkg.sv
// rtl/rf_iw_pkg.sv - shared constants for the double-buffer activation/weight RF and its fill controller
//
// Purpose:
//   Holds the 2-bit state encoding of the fill controller FSM and the default
//   widths/depth shared by the RF and the blocks that write into it.
//   This file has no ports.

package rf_iw_pkg;

  // Fill controller FSM encoding
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  // Default geometry shared with the RF
  localparam int DEF_DATA_BITWIDTH     = 8;
  localparam int DEF_ADDR_BITWIDTH     = 2;
  localparam int DEF_DEPTH             = 4;
  localparam int DEF_TILE_CNT_BITWIDTH = 16;

endpackage : rf_iw_pkg

// File: rtl/rf_iw_fill_ctrl.sv
// rtl/rf_iw_fill_ctrl.sv - write-side tile fill controller for the double-buffer activation/weight RF
//
// Purpose:
//   Accepts a valid/ready word stream from the global buffer and writes
//   DEPTH-word tiles into the fill bank of the RF. Banks are swapped only when
//   the consumer has released the read bank (or the read bank is empty).
//
// Optional feature macro: FILL_PERF_CNT_EN
//   Defined   : stall_cycles counts FULL cycles in which no swap happens
//               (saturating, cleared on an accepted start).
//   Undefined : stall_cycles is tied to 0.
//
// Ports:
//   clk            in   clock, all state on the rising edge
//   reset          in   asynchronous active-low reset
//   start          in   pulse, begin a job (ignored unless idle)
//   num_tiles      in   tiles in the job, sampled on an accepted start
//   gb_data        in   word from the global buffer
//   gb_valid       in   gb_data valid
//   gb_ready       out  a word is accepted this cycle (combinational, FILL only)
//   cons_done      in   pulse, consumer finished with the current read bank
//   write_sel      out  1 = fill mem1 / read mem2, 0 = fill mem2 / read mem1
//   write_en       out  RF write enable
//   w_addr         out  RF write address (both banks)
//   w_data         out  RF write data (both banks)
//   rd_bank_valid  out  read bank holds a complete tile
//   busy           out  job in progress
//   done           out  one-cycle pulse at the end of a job
//   stall_cycles   out  consumer-stall counter

module rf_iw_fill_ctrl
  import rf_iw_pkg::*;
#(
  parameter int DATA_BITWIDTH     = DEF_DATA_BITWIDTH,
  parameter int ADDR_BITWIDTH     = DEF_ADDR_BITWIDTH,
  parameter int DEPTH             = DEF_DEPTH,
  parameter int TILE_CNT_BITWIDTH = DEF_TILE_CNT_BITWIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [TILE_CNT_BITWIDTH-1:0] num_tiles,
  input  logic [DATA_BITWIDTH-1:0]     gb_data,
  input  logic                         gb_valid,
  output logic                         gb_ready,
  input  logic                         cons_done,
  output logic                         write_sel,
  output logic                         write_en,
  output logic [ADDR_BITWIDTH-1:0]     w_addr,
  output logic [DATA_BITWIDTH-1:0]     w_data,
  output logic                         rd_bank_valid,
  output logic                         busy,
  output logic                         done,
  output logic [31:0]                  stall_cycles
);

  localparam logic [ADDR_BITWIDTH-1:0]     LAST_WORD = ADDR_BITWIDTH'(DEPTH - 1);
  localparam logic [ADDR_BITWIDTH-1:0]     ADDR_ONE  = ADDR_BITWIDTH'(1);
  localparam logic [TILE_CNT_BITWIDTH-1:0] TILE_ONE  = TILE_CNT_BITWIDTH'(1);

  logic [1:0]                   state;
  logic [ADDR_BITWIDTH-1:0]     word_cnt;
  logic [TILE_CNT_BITWIDTH-1:0] tile_cnt;
  logic [TILE_CNT_BITWIDTH-1:0] num_tiles_q;
  logic                         beat;
  logic                         swap;
  logic                         start_ok;

  assign gb_ready = (state == FILL);
  assign beat     = gb_valid && gb_ready;
  assign start_ok = start && (state == IDLE);

  // A swap in FULL is allowed when the read bank is empty or is being
  // released this very cycle; the new tile keeps rd_bank_valid high.
  assign swap = (state == FULL) && (!rd_bank_valid || cons_done);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      write_sel     <= 1'b1;
      write_en      <= 1'b0;
      w_addr        <= '0;
      w_data        <= '0;
      rd_bank_valid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      word_cnt      <= '0;
      tile_cnt      <= '0;
      num_tiles_q   <= '0;
    end else begin
      write_en <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (cons_done && rd_bank_valid) begin
            rd_bank_valid <= 1'b0;
          end
          if (start) begin
            if (num_tiles != '0) begin
              state       <= FILL;
              busy        <= 1'b1;
              num_tiles_q <= num_tiles;
              tile_cnt    <= '0;
              word_cnt    <= '0;
            end else begin
              done <= 1'b1;
            end
          end
        end

        FILL: begin
          if (cons_done && rd_bank_valid) begin
            rd_bank_valid <= 1'b0;
          end
          if (beat) begin
            write_en <= 1'b1;
            w_addr   <= word_cnt;
            w_data   <= gb_data;
            if (word_cnt == LAST_WORD) begin
              word_cnt <= '0;
              state    <= FULL;
            end else begin
              word_cnt <= word_cnt + ADDR_ONE;
            end
          end
        end

        FULL: begin
          // The last write was registered on entry to FULL, so it lands in the
          // RF on this edge with the old write_sel before the toggle is seen.
          if (swap) begin
            write_sel     <= ~write_sel;
            rd_bank_valid <= 1'b1;
            tile_cnt      <= tile_cnt + TILE_ONE;
            if ((tile_cnt + TILE_ONE) == num_tiles_q) begin
              state <= DRAIN;
            end else begin
              state <= FILL;
            end
          end
        end

        DRAIN: begin
          if (cons_done) begin
            rd_bank_valid <= 1'b0;
            done          <= 1'b1;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FILL_PERF_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (start_ok) begin
      stall_cnt <= '0;
    end else if ((state == FULL) && !swap && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule : rf_iw_fill_ctrl

// File: tb/tb_rf_iw_fill_ctrl.sv
// tb/tb_rf_iw_fill_ctrl.sv - directed self-checking bench for rf_iw_fill_ctrl

module tb_rf_iw_fill_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] num_tiles;
  logic [7:0]  gb_data;
  logic        gb_valid;
  logic        gb_ready;
  logic        cons_done;
  logic        write_sel;
  logic        write_en;
  logic [1:0]  w_addr;
  logic [7:0]  w_data;
  logic        rd_bank_valid;
  logic        busy;
  logic        done;
  logic [31:0] stall_cycles;

  int errors = 0;
  int checks = 0;
  logic exp_ws;
  logic [31:0] exp_stall;

  rf_iw_fill_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .num_tiles     (num_tiles),
    .gb_data       (gb_data),
    .gb_valid      (gb_valid),
    .gb_ready      (gb_ready),
    .cons_done     (cons_done),
    .write_sel     (write_sel),
    .write_en      (write_en),
    .w_addr        (w_addr),
    .w_data        (w_data),
    .rd_bank_valid (rd_bank_valid),
    .busy          (busy),
    .done          (done),
    .stall_cycles  (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++; if (write_sel !== 1'b1) begin errors++; $display("FAIL reset_write_sel got %0b exp 1", write_sel); end
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL reset_write_en got %0b exp 0", write_en); end
    checks++; if (w_addr !== 2'd0 || w_data !== 8'h00) begin errors++; $display("FAIL reset_addr_data got %0h/%0h exp 0/0", w_addr, w_data); end
    checks++; if (gb_ready !== 1'b0 || rd_bank_valid !== 1'b0) begin errors++; $display("FAIL reset_ready_rbv got %0b/%0b exp 0/0", gb_ready, rd_bank_valid); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %0b/%0b exp 0/0", busy, done); end
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_stall got %0d exp 0", stall_cycles); end
    reset = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || gb_ready !== 1'b0) begin errors++; $display("FAIL idle_after_reset got busy=%0b ready=%0b exp 0/0", busy, gb_ready); end
  endtask

  task automatic test_single_tile();
    logic [7:0] d [4];
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
    start = 1'b1; num_tiles = 16'd1;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1 || gb_ready !== 1'b1) begin errors++; $display("FAIL single_enter_fill got busy=%0b ready=%0b exp 1/1", busy, gb_ready); end
    gb_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      gb_data = d[k];
      tick();
      checks++;
      if (write_en !== 1'b1 || w_addr !== 2'(k) || w_data !== d[k]) begin
        errors++; $display("FAIL single_beat%0d got we=%0b addr=%0d data=%0h exp 1/%0d/%0h", k, write_en, w_addr, w_data, k, d[k]);
      end
    end
    gb_valid = 1'b0;
    checks++; if (gb_ready !== 1'b0 || write_sel !== 1'b1) begin errors++; $display("FAIL single_full got ready=%0b ws=%0b exp 0/1", gb_ready, write_sel); end
    tick();
    exp_ws = 1'b0;
    checks++; if (write_sel !== exp_ws || write_en !== 1'b0) begin errors++; $display("FAIL single_swap got ws=%0b we=%0b exp 0/0", write_sel, write_en); end
    checks++; if (rd_bank_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL single_drain got rbv=%0b busy=%0b done=%0b exp 1/1/0", rd_bank_valid, busy, done); end
    tick();
    checks++; if (rd_bank_valid !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL single_drain_wait got rbv=%0b done=%0b exp 1/0", rd_bank_valid, done); end
    cons_done = 1'b1;
    tick();
    cons_done = 1'b0;
    checks++; if (done !== 1'b1 || busy !== 1'b0 || rd_bank_valid !== 1'b0) begin errors++; $display("FAIL single_done got done=%0b busy=%0b rbv=%0b exp 1/0/0", done, busy, rd_bank_valid); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_pulse got %0b exp 0", done); end
  endtask

  task automatic test_bubbles();
    int beat_idx;
    logic v;
    beat_idx = 0;
    start = 1'b1; num_tiles = 16'd1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      v = (i % 2 == 0);
      gb_valid = v;
      gb_data  = 8'(8'hA0 + i);
      tick();
      checks++;
      if (write_en !== v) begin
        errors++; $display("FAIL bubble_we%0d got %0b exp %0b", i, write_en, v);
      end else if (v && (w_addr !== 2'(beat_idx) || w_data !== 8'(8'hA0 + i))) begin
        errors++; $display("FAIL bubble_addr%0d got addr=%0d data=%0h exp %0d/%0h", i, w_addr, w_data, beat_idx, 8'(8'hA0 + i));
      end
      if (v) beat_idx++;
    end
    gb_valid = 1'b0;
    checks++; if (gb_ready !== 1'b0) begin errors++; $display("FAIL bubble_full got ready=%0b exp 0", gb_ready); end
    tick();
    exp_ws = ~exp_ws;
    checks++; if (write_sel !== exp_ws || rd_bank_valid !== 1'b1) begin errors++; $display("FAIL bubble_swap got ws=%0b rbv=%0b exp %0b/1", write_sel, rd_bank_valid, exp_ws); end
    cons_done = 1'b1;
    tick();
    cons_done = 1'b0;
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL bubble_done got done=%0b busy=%0b exp 1/0", done, busy); end
    tick();
  endtask

  task automatic test_back_to_back();
`ifdef FILL_PERF_CNT_EN
    exp_stall = 32'd7;
`else
    exp_stall = 32'd0;
`endif
    start = 1'b1; num_tiles = 16'd3; gb_valid = 1'b1; gb_data = 8'h30;
    tick();
    start = 1'b0;
    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < 4; k++) begin
        checks++; if (gb_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_t%0d_k%0d got %0b exp 1", t, k, gb_ready); end
        gb_data = 8'(8'h30 + t * 4 + k);
        // A start while busy must not restart or shorten the job.
        if (t == 1 && k == 1) begin start = 1'b1; num_tiles = 16'd1; end
        tick();
        start = 1'b0;
        checks++;
        if (write_en !== 1'b1 || w_addr !== 2'(k) || w_data !== 8'(8'h30 + t * 4 + k)) begin
          errors++; $display("FAIL b2b_beat_t%0d_k%0d got we=%0b addr=%0d data=%0h exp 1/%0d/%0h", t, k, write_en, w_addr, w_data, k, 8'(8'h30 + t * 4 + k));
        end
      end
      checks++; if (gb_ready !== 1'b0 || write_sel !== exp_ws) begin errors++; $display("FAIL b2b_full_t%0d got ready=%0b ws=%0b exp 0/%0b", t, gb_ready, write_sel, exp_ws); end
      if (t == 1) begin
        for (int s = 0; s < 7; s++) begin
          tick();
          checks++;
          if (gb_ready !== 1'b0 || write_en !== 1'b0 || write_sel !== exp_ws || rd_bank_valid !== 1'b1) begin
            errors++; $display("FAIL b2b_stall%0d got ready=%0b we=%0b ws=%0b rbv=%0b exp 0/0/%0b/1", s, gb_ready, write_en, write_sel, rd_bank_valid, exp_ws);
          end
        end
      end
      if (t > 0) cons_done = 1'b1;
      tick();
      cons_done = 1'b0;
      exp_ws = ~exp_ws;
      checks++; if (write_sel !== exp_ws || rd_bank_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL b2b_swap_t%0d got ws=%0b rbv=%0b busy=%0b exp %0b/1/1", t, write_sel, rd_bank_valid, busy, exp_ws); end
      if (t == 1) begin
        checks++; if (stall_cycles !== exp_stall) begin errors++; $display("FAIL b2b_stall_count got %0d exp %0d", stall_cycles, exp_stall); end
      end
    end
    gb_valid = 1'b0;
    checks++; if (gb_ready !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL b2b_drain got ready=%0b done=%0b exp 0/0", gb_ready, done); end
    cons_done = 1'b1;
    tick();
    cons_done = 1'b0;
    checks++; if (done !== 1'b1 || busy !== 1'b0 || rd_bank_valid !== 1'b0) begin errors++; $display("FAIL b2b_done got done=%0b busy=%0b rbv=%0b exp 1/0/0", done, busy, rd_bank_valid); end
    checks++; if (stall_cycles !== exp_stall) begin errors++; $display("FAIL b2b_stall_final got %0d exp %0d", stall_cycles, exp_stall); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_pulse got %0b exp 0", done); end
  endtask

  task automatic test_zero_tiles();
    start = 1'b1; num_tiles = 16'd0; gb_valid = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (done !== 1'b1 || busy !== 1'b0 || write_en !== 1'b0 || gb_ready !== 1'b0) begin errors++; $display("FAIL zero_done got done=%0b busy=%0b we=%0b ready=%0b exp 1/0/0/0", done, busy, write_en, gb_ready); end
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL zero_stall_clear got %0d exp 0", stall_cycles); end
    tick();
    checks++; if (done !== 1'b0 || write_en !== 1'b0 || write_sel !== exp_ws) begin errors++; $display("FAIL zero_after got done=%0b we=%0b ws=%0b exp 0/0/%0b", done, write_en, write_sel, exp_ws); end
    gb_valid = 1'b0;
  endtask

  task automatic test_reset_midfill();
    start = 1'b1; num_tiles = 16'd2; gb_valid = 1'b1; gb_data = 8'h5A;
    tick();
    start = 1'b0;
    tick();
    tick();
    checks++; if (write_en !== 1'b1 || w_addr !== 2'd1) begin errors++; $display("FAIL midfill_pre got we=%0b addr=%0d exp 1/1", write_en, w_addr); end
    #2 reset = 1'b0;
    #1;
    checks++; if (write_en !== 1'b0 || busy !== 1'b0 || gb_ready !== 1'b0) begin errors++; $display("FAIL midfill_async got we=%0b busy=%0b ready=%0b exp 0/0/0", write_en, busy, gb_ready); end
    checks++; if (write_sel !== 1'b1 || w_addr !== 2'd0 || w_data !== 8'h00 || rd_bank_valid !== 1'b0) begin errors++; $display("FAIL midfill_vals got ws=%0b addr=%0d data=%0h rbv=%0b exp 1/0/0/0", write_sel, w_addr, w_data, rd_bank_valid); end
    tick();
    tick();
    checks++; if (write_en !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midfill_held got we=%0b done=%0b exp 0/0", write_en, done); end
    gb_valid = 1'b0;
    reset = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || write_en !== 1'b0) begin errors++; $display("FAIL midfill_release got busy=%0b we=%0b exp 0/0", busy, write_en); end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; num_tiles = '0; gb_data = '0; gb_valid = 1'b0; cons_done = 1'b0;
    exp_ws = 1'b1; exp_stall = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_single_tile();
    test_bubbles();
    test_back_to_back();
    test_zero_tiles();
    test_reset_midfill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_rf_iw_fill_ctrl
